// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
//   Sequences the two-digit BCD countdown (tens + units) of the timer datapath.
//   A preset is loaded and clamped to legal BCD digits. Once started, the count
//   decrements once per prescaled tick, with a borrow from units into tens.
//   The countdown can be paused, resumed or stopped, and it flags the 00 end
//   condition.
//
// Parameters
//   CLK_DIV   clock cycles per countdown tick (>= 2)
//   TENS_MAX  highest legal tens digit (0..9)
//
// Ports
//   clock         in   1  system clock, rising edge
//   reset_n       in   1  synchronous reset, active-low
//   load          in   1  pulse: capture preset_* digits (IDLE/DONE only)
//   start         in   1  pulse: start countdown / resume from pause
//   pause         in   1  pulse: freeze countdown
//   stop          in   1  pulse: abort, clear to 00
//   preset_units  in   4  BCD units preset
//   preset_tens   in   4  BCD tens preset
//   bcd_units     out  4  current units digit
//   bcd_tens      out  4  current tens digit
//   running       out  1  high in RUN
//   paused        out  1  high in PAUSE
//   done          out  1  one-cycle pulse when the count reaches 00 in RUN
//   K_end         out  1  level: count == 00 (combinational)
// -----------------------------------------------------------------------------
module countdown_ctrl #(
   parameter int unsigned CLK_DIV  = 50_000_000,
   parameter int unsigned TENS_MAX = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       load,
   input  logic       start,
   input  logic       pause,
   input  logic       stop,
   input  logic [3:0] preset_units,
   input  logic [3:0] preset_tens,
   output logic [3:0] bcd_units,
   output logic [3:0] bcd_tens,
   output logic       running,
   output logic       paused,
   output logic       done,
   output logic       K_end
);

   localparam int unsigned   PW         = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [3:0]    TENS_LIM   = 4'(TENS_MAX);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      DONE
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    units_q, units_d;
   logic [3:0]    tens_q,  tens_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          running_q, running_d;
   logic          paused_q,  paused_d;
   logic          done_q,    done_d;

   logic [3:0] load_units, load_tens;
   logic [3:0] dec_units,  dec_tens;
   logic       count_zero, dec_zero, tick;

   // Each preset digit is clamped to its own legal maximum.
   assign load_units = (preset_units > 4'd9)   ? 4'd9     : preset_units;
   assign load_tens  = (preset_tens  > TENS_LIM) ? TENS_LIM : preset_tens;

   assign count_zero = (units_q == 4'd0) && (tens_q == 4'd0);

   // A decrement from 00 cannot occur: RUN is only entered with a non-zero
   // count, and it is left for DONE as soon as the count reaches 00.
   assign dec_units = (units_q == 4'd0) ? 4'd9 : units_q - 4'd1;
   assign dec_tens  = (units_q == 4'd0) ? tens_q - 4'd1 : tens_q;
   assign dec_zero  = (dec_units == 4'd0) && (dec_tens == 4'd0);

   assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

   always_comb begin
      state_d = state_q;
      units_d = units_q;
      tens_d  = tens_q;
      presc_d = presc_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A stop pulse in IDLE does not change anything, but it still
            // masks a load or a start in the same cycle.
            if (!stop) begin
               if (load) begin
                  units_d = load_units;
                  tens_d  = load_tens;
               end else if (start && !count_zero) begin
                  state_d = RUN;
                  presc_d = '0;
               end
            end
         end

         RUN: begin
            if (stop) begin
               state_d = IDLE;
               units_d = '0;
               tens_d  = '0;
               presc_d = '0;
            end else begin
               // The prescaler advances on every RUN cycle. This includes the
               // cycle in which a pause arrives, so a resume continues
               // exactly where the partial tick stopped.
               if (tick) begin
                  units_d = dec_units;
                  tens_d  = dec_tens;
                  presc_d = '0;
               end else begin
                  presc_d = presc_q + PW'(1);
               end
               if (tick && dec_zero) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else if (pause) begin
                  state_d = PAUSE;
               end
            end
         end

         PAUSE: begin
            if (stop) begin
               state_d = IDLE;
               units_d = '0;
               tens_d  = '0;
               presc_d = '0;
            end else if (start) begin
               state_d = RUN;
            end
         end

         DONE: begin
            if (stop) begin
               state_d = IDLE;
               units_d = '0;
               tens_d  = '0;
               presc_d = '0;
            end else if (load) begin
               state_d = IDLE;
               units_d = load_units;
               tens_d  = load_tens;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      running_d = (state_d == RUN);
      paused_d  = (state_d == PAUSE);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         units_q   <= '0;
         tens_q    <= '0;
         presc_q   <= '0;
         running_q <= 1'b0;
         paused_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         units_q   <= units_d;
         tens_q    <= tens_d;
         presc_q   <= presc_d;
         running_q <= running_d;
         paused_q  <= paused_d;
         done_q    <= done_d;
      end
   end

   assign bcd_units = units_q;
   assign bcd_tens  = tens_q;
   assign running   = running_q;
   assign paused    = paused_q;
   assign done      = done_q;
   assign K_end     = count_zero;

endmodule

// File: tb/tb_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_countdown_ctrl
//   Self-checking bench for countdown_ctrl with CLK_DIV=4 and TENS_MAX=1.
//   Directed scenarios use expected values taken from the countdown rules.
//   A randomized phase compares the DUT every cycle with a decimal-count
//   reference model.
// -----------------------------------------------------------------------------
module tb_countdown_ctrl;

   localparam int CLK_DIV  = 4;
   localparam int TENS_MAX = 1;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       load = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0;
   logic [3:0] preset_units = 4'd0, preset_tens = 4'd0;
   logic [3:0] bcd_units, bcd_tens;
   logic       running, paused, done, K_end;

   int errors = 0;
   int checks = 0;

   // Reference model: the count is a plain decimal number 0..99, and the
   // position inside a tick is the number of RUN cycles elapsed since the
   // last tick.
   int m_count = 0;
   int m_mode  = M_IDLE;
   int m_phase = 0;
   bit m_done  = 1'b0;

   always #5 clock = ~clock;

   countdown_ctrl #(
      .CLK_DIV (CLK_DIV),
      .TENS_MAX(TENS_MAX)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .load        (load),
      .start       (start),
      .pause       (pause),
      .stop        (stop),
      .preset_units(preset_units),
      .preset_tens (preset_tens),
      .bcd_units   (bcd_units),
      .bcd_tens    (bcd_tens),
      .running     (running),
      .paused      (paused),
      .done        (done),
      .K_end       (K_end)
   );

   function automatic int dut_count();
      return int'(bcd_tens) * 10 + int'(bcd_units);
   endfunction

   function automatic int clamped(input logic [3:0] u, input logic [3:0] t);
      int uu, tt;
      uu = (int'(u) > 9) ? 9 : int'(u);
      tt = (int'(t) > TENS_MAX) ? TENS_MAX : int'(t);
      return tt * 10 + uu;
   endfunction

   task automatic model_step();
      bit was_tick;
      m_done = 1'b0;
      if (!reset_n) begin
         m_count = 0;
         m_mode  = M_IDLE;
         m_phase = 0;
         return;
      end
      was_tick = (m_mode == M_RUN) && (m_phase == CLK_DIV - 1);
      case (m_mode)
         M_IDLE: begin
            if (stop) begin
            end else if (load) begin
               m_count = clamped(preset_units, preset_tens);
            end else if (start && m_count != 0) begin
               m_mode  = M_RUN;
               m_phase = 0;
            end
         end
         M_RUN: begin
            if (stop) begin
               m_mode = M_IDLE; m_count = 0; m_phase = 0;
            end else begin
               if (was_tick) begin
                  m_count = m_count - 1;
                  m_phase = 0;
               end else begin
                  m_phase = m_phase + 1;
               end
               if (was_tick && m_count == 0) begin
                  m_mode = M_DONE;
                  m_done = 1'b1;
               end else if (pause) begin
                  m_mode = M_PAUSE;
               end
            end
         end
         M_PAUSE: begin
            if (stop) begin
               m_mode = M_IDLE; m_count = 0; m_phase = 0;
            end else if (start) begin
               m_mode = M_RUN;
            end
         end
         default: begin
            if (stop) begin
               m_mode = M_IDLE; m_count = 0; m_phase = 0;
            end else if (load) begin
               m_mode  = M_IDLE;
               m_count = clamped(preset_units, preset_tens);
            end
         end
      endcase
   endtask

   // Drives one cycle of inputs from the falling edge, advances the model at
   // the rising edge, and returns 1 time unit later for sampling.
   task automatic cyc(input logic l, input logic s, input logic p, input logic st,
                      input logic [3:0] pu = 4'd0, input logic [3:0] pt = 4'd0,
                      input logic rn = 1'b1);
      @(negedge clock);
      load = l; start = s; pause = p; stop = st;
      preset_units = pu; preset_tens = pt; reset_n = rn;
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      checks++;
      if ({bcd_tens, bcd_units, running, paused, done, K_end} !== {4'd0, 4'd0, 4'b0001}) begin
         errors++;
         $display("FAIL reset_state: got t=%0d u=%0d run=%b pau=%b done=%b kend=%b, want 0 0 0 0 0 1",
                  bcd_tens, bcd_units, running, paused, done, K_end);
      end
   endtask

   task automatic test_countdown();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd1);
      checks++;
      if (dut_count() !== 12 || running !== 1'b0) begin
         errors++; $display("FAIL load_12: got count=%0d run=%b, want 12 0", dut_count(), running);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (running !== 1'b1 || dut_count() !== 12) begin
         errors++; $display("FAIL start_run: got run=%b count=%0d, want 1 12", running, dut_count());
      end
      idle(3);
      checks++;
      if (dut_count() !== 12) begin
         errors++; $display("FAIL pre_tick: got %0d, want 12", dut_count());
      end
      idle(1);
      checks++;
      if (dut_count() !== 11) begin
         errors++; $display("FAIL tick4: got %0d, want 11", dut_count());
      end
      idle(4);
      checks++;
      if (dut_count() !== 10) begin
         errors++; $display("FAIL tick8: got %0d, want 10", dut_count());
      end
      idle(4);
      checks++;
      if ({bcd_tens, bcd_units} !== {4'd0, 4'd9}) begin
         errors++; $display("FAIL borrow: got %0d%0d, want 09", bcd_tens, bcd_units);
      end
      idle(35);
      checks++;
      if (dut_count() !== 1 || done !== 1'b0 || K_end !== 1'b0) begin
         errors++; $display("FAIL before_end: got count=%0d done=%b kend=%b, want 1 0 0", dut_count(), done, K_end);
      end
      idle(1);
      checks++;
      if (dut_count() !== 0 || done !== 1'b1 || K_end !== 1'b1 || running !== 1'b0) begin
         errors++; $display("FAIL reach_00: got count=%0d done=%b kend=%b run=%b, want 0 1 1 0",
                            dut_count(), done, K_end, running);
      end
      idle(1);
      checks++;
      if (done !== 1'b0 || dut_count() !== 0) begin
         errors++; $display("FAIL done_pulse: got done=%b count=%0d, want 0 0", done, dut_count());
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (running !== 1'b0 || dut_count() !== 0) begin
         errors++; $display("FAIL start_in_done: got run=%b count=%0d, want 0 0", running, dut_count());
      end
   endtask

   task automatic test_pause_resume();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0);
      checks++;
      if (dut_count() !== 5 || running !== 1'b0) begin
         errors++; $display("FAIL load_from_done: got count=%0d run=%b, want 5 0", dut_count(), running);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (paused !== 1'b1 || running !== 1'b0) begin
         errors++; $display("FAIL pause_enter: got pau=%b run=%b, want 1 0", paused, running);
      end
      idle(19);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 4'd1);
      checks++;
      if (dut_count() !== 5 || paused !== 1'b1) begin
         errors++; $display("FAIL pause_hold: got count=%0d pau=%b, want 5 1", dut_count(), paused);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);
      checks++;
      if (dut_count() !== 5 || running !== 1'b1) begin
         errors++; $display("FAIL resume_early: got count=%0d run=%b, want 5 1", dut_count(), running);
      end
      idle(1);
      checks++;
      if (dut_count() !== 4) begin
         errors++; $display("FAIL resume_tick: got %0d, want 4", dut_count());
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_clamp();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'hC, 4'd7);
      checks++;
      if ({bcd_tens, bcd_units} !== {4'd1, 4'd9}) begin
         errors++; $display("FAIL clamp: got %0d%0d, want 19", bcd_tens, bcd_units);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0);
      checks++;
      if (dut_count() !== 19 || running !== 1'b1) begin
         errors++; $display("FAIL load_in_run: got count=%0d run=%b, want 19 1", dut_count(), running);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_stop_and_zero_start();
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (running !== 1'b0 || paused !== 1'b0 || dut_count() !== 0) begin
         errors++; $display("FAIL start_at_00: got run=%b pau=%b count=%0d, want 0 0 0", running, paused, dut_count());
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (dut_count() !== 0 || running !== 1'b0 || done !== 1'b0 || K_end !== 1'b1) begin
         errors++; $display("FAIL stop_in_run: got count=%0d run=%b done=%b kend=%b, want 0 0 0 1",
                            dut_count(), running, done, K_end);
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (dut_count() !== 0 || running !== 1'b0 || paused !== 1'b0) begin
         errors++; $display("FAIL stop_over_pause: got count=%0d run=%b pau=%b, want 0 0 0", dut_count(), running, paused);
      end
   endtask

   task automatic test_pause_on_tick();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (dut_count() !== 0 || done !== 1'b1 || paused !== 1'b0 || running !== 1'b0) begin
         errors++; $display("FAIL pause_tick_00: got count=%0d done=%b pau=%b run=%b, want 0 1 0 0",
                            dut_count(), done, paused, running);
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (dut_count() !== 4 || paused !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL pause_tick_nz: got count=%0d pau=%b done=%b, want 4 1 0", dut_count(), paused, done);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 4'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(5);
      checks++;
      if (dut_count() !== 7 || running !== 1'b1) begin
         errors++; $display("FAIL mid_run: got count=%0d run=%b, want 7 1", dut_count(), running);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      checks++;
      if ({bcd_tens, bcd_units, running, paused, done, K_end} !== {4'd0, 4'd0, 4'b0001}) begin
         errors++; $display("FAIL reset_mid_run: got t=%0d u=%0d run=%b pau=%b done=%b kend=%b, want 0 0 0 0 0 1",
                            bcd_tens, bcd_units, running, paused, done, K_end);
      end
   endtask

   task automatic test_random();
      logic       l, s, p, st, rn;
      logic [3:0] pu, pt;
      logic [11:0] exp_v, got_v;
      int r;
      for (int i = 0; i < 1500; i++) begin
         l = 1'b0; s = 1'b0; p = 1'b0; st = 1'b0; rn = 1'b1;
         r  = int'($urandom_range(0, 31));
         pu = 4'($urandom);
         pt = 4'($urandom_range(0, 3));
         case (r)
            0:       l = 1'b1;
            1, 2:    s = 1'b1;
            3:       p = 1'b1;
            4:       st = 1'b1;
            5:       rn = ($urandom_range(0, 7) != 0);
            default: ;
         endcase
         cyc(l, s, p, st, pu, pt, rn);
         exp_v = {4'(m_count / 10), 4'(m_count % 10), (m_mode == M_RUN), (m_mode == M_PAUSE),
                  m_done, (m_count == 0)};
         got_v = {bcd_tens, bcd_units, running, paused, done, K_end};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL random[%0d]: got t/u/run/pau/done/kend=%0d/%0d/%b/%b/%b/%b, want %0d/%0d/%b/%b/%b/%b",
                     i, got_v[11:8], got_v[7:4], got_v[3], got_v[2], got_v[1], got_v[0],
                     exp_v[11:8], exp_v[7:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_pause_resume();
      test_clamp();
      test_stop_and_zero_start();
      test_pause_on_tick();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
